reservation_pool: RTL and testbench
===================================

RESERVATION_POOL -- requirements
Module: reservation_pool

Interface
REQ-001 Parameter ID_WIDTH, default BLOCK_COUNT_BITS: width of a reservation id.
REQ-002 Parameter DEPTH, default BLOCK_COUNT: number of ids in the pool; SHALL equal 2**ID_WIDTH.
REQ-003 clk  in  1  clock; all logic on posedge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 reservation_dequeue  in  1  one-cycle pop request from the allocator.
REQ-006 reservation_id  out  ID_WIDTH  last popped id, registered.
REQ-007 release  in  1  one-cycle push request from the free path.
REQ-008 release_id  in  ID_WIDTH  id returned to the pool when release is high.
REQ-009 init_done  out  1  high once the pool is initialised.
REQ-010 empty  out  1  high when count == 0.
REQ-011 count  out  ID_WIDTH+1  number of free ids held.
REQ-012 underflow_err  out  1  one-cycle pulse on an unserviceable dequeue.
REQ-013 overflow_err  out  1  one-cycle pulse on a dropped release.

Function
REQ-014 Storage SHALL be a circular FIFO of DEPTH entries: rd_ptr and wr_ptr are ID_WIDTH bits, wrap modulo DEPTH, and count is ID_WIDTH+1 bits.
REQ-015 The state machine SHALL have states POOL_INIT and POOL_READY; reset SHALL enter POOL_INIT.
REQ-016 In POOL_INIT an init counter SHALL write mem[i] = i, one entry per cycle, for i = 0..DEPTH-1.
REQ-017 POOL_INIT SHALL last exactly DEPTH cycles; it then sets count = DEPTH, rd_ptr = 0, wr_ptr = 0, init_done = 1 and moves to POOL_READY.
REQ-018 In POOL_INIT, dequeue SHALL pulse underflow_err and release SHALL pulse overflow_err; neither changes state.
REQ-019 In POOL_READY, dequeue with count > 0 SHALL load reservation_id <= mem[rd_ptr] at that edge and advance rd_ptr; the id is valid the cycle after dequeue and held until the next successful dequeue.
REQ-020 In POOL_READY, release with count < DEPTH SHALL write mem[wr_ptr] <= release_id and advance wr_ptr.
REQ-021 Dequeue and release in the same cycle with 0 < count SHALL perform both operations; count is unchanged.
REQ-022 Dequeue and release in the same cycle with count == 0 SHALL bypass: reservation_id <= release_id, pointers and count unchanged, no error.
REQ-023 Dequeue alone with count == 0 SHALL pulse underflow_err for one cycle and leave reservation_id unchanged.
REQ-024 Release alone with count == DEPTH SHALL be dropped and SHALL pulse overflow_err for one cycle.
REQ-025 Error pulses SHALL be registered and SHALL deassert the following cycle unless re-triggered.
REQ-026 empty and count SHALL be registered and reflect state after each edge.

Reset
REQ-027 On rst_n low, outputs SHALL reset as follows: reservation_id = 0, init_done = 0, empty = 1, count = 0, underflow_err = 0, overflow_err = 0.
REQ-028 On rst_n low, internals SHALL reset as follows: pointers = 0, init counter = 0, state = POOL_INIT.
REQ-029 Reset asserted mid-operation, including mid-init, SHALL abort the operation and restart initialisation from id 0 when reset deasserts.

Configuration
REQ-030 With macro RESV_DOUBLE_FREE_CHECK_EN defined, a DEPTH-bit issued bitmap SHALL be kept: set on each id popped, cleared on each id released.
REQ-031 With RESV_DOUBLE_FREE_CHECK_EN defined, a release whose id is not set in the bitmap SHALL be dropped and SHALL pulse overflow_err.
REQ-032 With RESV_DOUBLE_FREE_CHECK_EN defined, the bitmap SHALL reset to all zero and SHALL be honoured in the bypass case of REQ-022.
REQ-033 Without RESV_DOUBLE_FREE_CHECK_EN, no bitmap SHALL be built and releases are checked only against count == DEPTH.

Verification
REQ-034 Reset, DEPTH=16 -> init_done rises exactly 16 cycles after rst_n release; count = 16, empty = 0.
REQ-035 After init, 3 dequeues on consecutive cycles -> reservation_id = 0, 1, 2, each on the cycle after its pulse; count = 13.
REQ-036 Dequeue 16 times, then dequeue again -> empty = 1 and one underflow_err pulse; reservation_id stays 15.
REQ-037 When empty, release(7) and dequeue in the same cycle -> reservation_id = 7 next cycle; count = 0; no error.
REQ-038 Full pool, release(3) -> overflow_err pulse; count stays 16. With RESV_DOUBLE_FREE_CHECK_EN: pop 5, release 5 twice -> second release pulses overflow_err.
REQ-039 Assert rst_n low at init cycle 8 -> init_done = 0; init restarts and completes 16 cycles after reset release.

Source files
------------

// File: rtl/reservation_pool.sv
// Circular free-id pool: self-initialises to ids 0..DEPTH-1, pops ids on dequeue and accepts them back on release.
// Optional RESV_DOUBLE_FREE_CHECK_EN keeps an issued-id bitmap and drops releases of ids that were never handed out.
`ifndef BLOCK_COUNT_BITS
`define BLOCK_COUNT_BITS 4
`endif
`ifndef BLOCK_COUNT
`define BLOCK_COUNT 16
`endif

module reservation_pool #(
    parameter int ID_WIDTH = `BLOCK_COUNT_BITS,
    parameter int DEPTH    = `BLOCK_COUNT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reservation_dequeue,
    output logic [ID_WIDTH-1:0] reservation_id,
    // "release" is a reserved word, hence the suffix
    input  logic                release_req,
    input  logic [ID_WIDTH-1:0] release_id,
    output logic                init_done,
    output logic                empty,
    output logic [ID_WIDTH:0]   count,
    output logic                underflow_err,
    output logic                overflow_err
);

    typedef enum logic {POOL_INIT, POOL_READY} state_t;

    state_t              state, state_next;
    logic [ID_WIDTH-1:0] mem [DEPTH];
    logic [ID_WIDTH-1:0] rd_ptr, wr_ptr, init_cnt;
    logic [ID_WIDTH:0]   count_next;
    logic                init_last, ready, have_id, full;
    logic                rel_id_ok, rel_ok, deq_pop, rel_push, bypass;
    logic                underflow_next, overflow_next;

`ifdef RESV_DOUBLE_FREE_CHECK_EN
    logic [DEPTH-1:0]    issued;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued <= '0;
        end else begin
            if (rel_push) issued[release_id] <= 1'b0;
            if (deq_pop)  issued[mem[rd_ptr]] <= 1'b1;
        end
    end

    assign rel_id_ok = issued[release_id];
`else
    assign rel_id_ok = 1'b1;
`endif

    assign init_last = (init_cnt == ID_WIDTH'(DEPTH - 1));
    assign ready     = (state == POOL_READY);
    assign have_id   = (count != '0);
    assign full      = (count == (ID_WIDTH+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= POOL_INIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            POOL_INIT:  if (init_last) state_next = POOL_READY;
            POOL_READY: state_next = POOL_READY;
            default:    state_next = POOL_INIT;
        endcase
    end

    // A full pool can still accept a release when a pop frees a slot in the same cycle.
    always_comb begin
        rel_ok         = release_req && rel_id_ok && (!full || reservation_dequeue);
        deq_pop        = ready && reservation_dequeue && have_id;
        bypass         = ready && reservation_dequeue && !have_id && rel_ok;
        rel_push       = ready && rel_ok && !(reservation_dequeue && !have_id);
        underflow_next = reservation_dequeue && (!ready || (!have_id && !rel_ok));
        overflow_next  = release_req && (!ready || !rel_ok);
        count_next     = count;
        if (rel_push && !deq_pop)      count_next = count + 1'b1;
        else if (deq_pop && !rel_push) count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            init_cnt       <= '0;
            count          <= '0;
            empty          <= 1'b1;
            init_done      <= 1'b0;
            reservation_id <= '0;
            underflow_err  <= 1'b0;
            overflow_err   <= 1'b0;
        end else begin
            underflow_err <= underflow_next;
            overflow_err  <= overflow_next;
            if (!ready) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_last) begin
                    count     <= (ID_WIDTH+1)'(DEPTH);
                    empty     <= 1'b0;
                    init_done <= 1'b1;
                    rd_ptr    <= '0;
                    wr_ptr    <= '0;
                end
            end else begin
                if (deq_pop) begin
                    reservation_id <= mem[rd_ptr];
                    rd_ptr         <= rd_ptr + 1'b1;
                end
                if (bypass)   reservation_id <= release_id;
                if (rel_push) wr_ptr <= wr_ptr + 1'b1;
                count <= count_next;
                empty <= (count_next == '0);
            end
        end
    end

    // Storage carries no reset; the init sweep fills it after every reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!ready)        mem[init_cnt] <= init_cnt;
            else if (rel_push) mem[wr_ptr]   <= release_id;
        end
    end

endmodule

// File: tb/tb_reservation_pool.sv
// Randomised and directed bench for reservation_pool against a queue-based model of the free-id pool.
`timescale 1ns/1ps
module tb_reservation_pool;
    localparam int IW = 4;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          deq = 1'b0;
    logic          rel = 1'b0;
    logic [IW-1:0] rel_id = '0;
    logic [IW-1:0] rid;
    logic          init_done, empty, uf, of;
    logic [IW:0]   cnt;

    int checks = 0;
    int errors = 0;

    // model state
    int q[$];
    bit issued[D];
    int m_id;
    bit m_done, m_uf, m_of;
    int init_left;

    always #5 clk = ~clk;

    reservation_pool #(.ID_WIDTH(IW), .DEPTH(D)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .reservation_dequeue (deq),
        .reservation_id      (rid),
        .release_req         (rel),
        .release_id          (rel_id),
        .init_done           (init_done),
        .empty               (empty),
        .count               (cnt),
        .underflow_err       (uf),
        .overflow_err        (of)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit ok;
        if (!rst_n) begin
            q.delete();
            foreach (issued[i]) issued[i] = 1'b0;
            m_id = 0; m_done = 0; m_uf = 0; m_of = 0; init_left = D;
        end else if (!m_done) begin
            m_uf = deq;
            m_of = rel;
            init_left--;
            if (init_left == 0) begin
                for (int i = 0; i < D; i++) q.push_back(i);
                m_done = 1;
            end
        end else begin
            m_uf = 0;
            m_of = 0;
            ok = rel && (q.size() < D || deq);
`ifdef RESV_DOUBLE_FREE_CHECK_EN
            ok = ok && issued[rel_id];
`endif
            if (deq && q.size() == 0) begin
                if (ok) m_id = int'(rel_id);
                else    m_uf = 1;
                if (rel && !ok) m_of = 1;
            end else begin
                if (deq) begin
                    m_id = q.pop_front();
                    issued[m_id] = 1'b1;
                end
                if (rel) begin
                    if (ok) begin
                        q.push_back(int'(rel_id));
                        issued[rel_id] = 1'b0;
                    end else begin
                        m_of = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        check("reservation_id", 32'(rid), m_id);
        check("init_done", 32'(init_done), 32'(m_done));
        check("count", 32'(cnt), q.size());
        check("empty", 32'(empty), (q.size() == 0) ? 1 : 0);
        check("underflow_err", 32'(uf), 32'(m_uf));
        check("overflow_err", 32'(of), 32'(m_of));
    endtask

    task automatic cycle(input bit r, input bit d, input bit l, input int id);
        rst_n  = r;
        deq    = d;
        rel    = l;
        rel_id = id[IW-1:0];
        @(posedge clk);
        model_edge();
        #1;
        compare();
        deq = 1'b0;
        rel = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(1, 0, 0, 0);
            if (init_done === 1'b1) begin
                n = i;
                break;
            end
        end
        check(name, n, 16);
    endtask

    initial begin
        cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 3);
        check("reset_count", 32'(cnt), 0);
        check("reset_empty", 32'(empty), 1);
        check("reset_init_done", 32'(init_done), 0);
        check("reset_id", 32'(rid), 0);

        wait_init("init_latency");
        check("init_count", 32'(cnt), 16);
        check("init_empty", 32'(empty), 0);

        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 0, 0);
            check("first_ids", 32'(rid), k);
        end
        check("count_after3", 32'(cnt), 13);

        for (int k = 3; k < 16; k++) cycle(1, 1, 0, 0);
        check("drain_id", 32'(rid), 15);
        check("drain_empty", 32'(empty), 1);
        cycle(1, 1, 0, 0);
        check("underflow_pulse", 32'(uf), 1);
        check("underflow_id_held", 32'(rid), 15);
        cycle(1, 0, 0, 0);
        check("underflow_clear", 32'(uf), 0);

        cycle(1, 1, 1, 7);
        check("bypass_id", 32'(rid), 7);
        check("bypass_count", 32'(cnt), 0);
        check("bypass_no_uf", 32'(uf), 0);
        check("bypass_no_of", 32'(of), 0);

        for (int k = 0; k < 16; k++) cycle(1, 0, 1, k);
        check("refill_count", 32'(cnt), 16);
        cycle(1, 0, 1, 3);
        check("full_overflow", 32'(of), 1);
        check("full_count", 32'(cnt), 16);

`ifdef RESV_DOUBLE_FREE_CHECK_EN
        for (int k = 0; k < 6; k++) cycle(1, 1, 0, 0);
        check("pop_to_5", 32'(rid), 5);
        cycle(1, 0, 1, 5);
        check("first_free_ok", 32'(of), 0);
        cycle(1, 0, 1, 5);
        check("double_free", 32'(of), 1);
`endif

        cycle(0, 0, 0, 0);
        for (int k = 0; k < 8; k++) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("midinit_reset_done", 32'(init_done), 0);
        wait_init("reinit_latency");

        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 99) < 45),
                  ($urandom_range(0, 99) < 45), int'($urandom_range(0, D - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
